pulse_toggle_encoder: RTL and testbench

//   N-channel pulse-to-toggle encoder with per-channel event backlog and a

---
 rtl/pulse_toggle_pkg.sv | 35 +++
 rtl/pulse_toggle_encoder_chan.sv | 99 +++++++++
 rtl/pulse_toggle_encoder.sv | 43 ++++
 tb/tb_pulse_toggle_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_toggle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_toggle_pkg
//  Purpose  : Shared constants and width helpers for the pulse-to-toggle
//             encoder (event-mode codes, gap-timer width, backlog limit).
//  Revision : 1.0 - initial release
// ============================================================================
package pulse_toggle_pkg;

    // Event qualification modes
    localparam int EDGE_LEVEL = 0;  // every high cycle is one event
    localparam int EDGE_RISE  = 1;  // only rising edges are events

    // Ceiling log2 for elaboration-time width math
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Gap timer width; a GAP of 1 still needs a 1-bit (always zero) timer
    function automatic int gap_width(input int gap);
        int w;
        w = clog2(gap);
        return (w < 1) ? 1 : w;
    endfunction

    // Largest backlog a CW-bit saturating pending counter can hold
    function automatic int pend_max(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_toggle_encoder_chan.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_toggle_chan
//  Purpose  : One encoder channel: event qualification, saturating backlog
//             counter, minimum-spacing gap timer, toggle output, sticky
//             overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_toggle_chan
    import pulse_toggle_pkg::*;
#(
    parameter int CW        = 3,
    parameter int GAP       = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    input  logic ovf_clr_i,
    output logic out_o,
    output logic busy_o,
    output logic ovf_o
);

    localparam int            GW         = gap_width(GAP);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);
    localparam logic [CW-1:0] PEND_FULL  = CW'(pend_max(CW));
    localparam logic [CW-1:0] PEND_ONE   = CW'(1);

    logic          in_q;
    logic          out_q, out_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] pend_q, pend_d;
    logic [GW-1:0] gap_q, gap_d;

    logic ev;
    logic fire;
    logic full;
    logic drop;

    // Next-state: deliver one event per open gap window, otherwise queue or drop
    always_comb begin
        ev     = (EDGE_MODE == EDGE_RISE) ? (in_i & ~in_q) : in_i;
        full   = (pend_q == PEND_FULL);
        fire   = (gap_q == '0) && ((pend_q != '0) || ev);
        drop   = ev && full && !fire;

        out_d  = out_q;
        pend_d = pend_q;
        gap_d  = gap_q;
        ovf_d  = ovf_q;

        if (fire) begin
            out_d = ~out_q;
            gap_d = GAP_RELOAD;
            // A new event replaces the delivered one, so pend only shrinks without ev
            if (!ev) begin
                pend_d = pend_q - PEND_ONE;
            end
        end else begin
            if (gap_q != '0) begin
                gap_d = gap_q - GAP_ONE;
            end
            if (ev && !full) begin
                pend_d = pend_q + PEND_ONE;
            end
        end

        // A drop in the same cycle as a clear keeps the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; in_q tracks the input even in reset so a held level is not an edge
    always_ff @(posedge clk) begin
        in_q <= in_i;
        if (reset) begin
            out_q  <= 1'b0;
            ovf_q  <= 1'b0;
            pend_q <= '0;
            gap_q  <= '0;
        end else begin
            out_q  <= out_d;
            ovf_q  <= ovf_d;
            pend_q <= pend_d;
            gap_q  <= gap_d;
        end
    end

    assign out_o  = out_q;
    assign ovf_o  = ovf_q;
    assign busy_o = (pend_q != '0) | (gap_q != '0);

endmodule
`default_nettype wire

// File: rtl/pulse_toggle_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_toggle_encoder
//  Purpose  : N-channel pulse-to-toggle encoder with per-channel backlog and
//             minimum toggle spacing, for toggle-based CDC source sides.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_toggle_encoder
    import pulse_toggle_pkg::*;
#(
    parameter int N         = 4,
    parameter int CW        = 3,
    parameter int GAP       = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic [N-1:0] ovf_clr,
    output logic [N-1:0] out,
    output logic [N-1:0] busy,
    output logic [N-1:0] ovf
);

    // Channels are fully independent; the top only slices the buses
    for (genvar g = 0; g < N; g++) begin : g_chan
        pulse_toggle_chan #(
            .CW        (CW),
            .GAP       (GAP),
            .EDGE_MODE (EDGE_MODE)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .in_i      (in[g]),
            .ovf_clr_i (ovf_clr[g]),
            .out_o     (out[g]),
            .busy_o    (busy[g]),
            .ovf_o     (ovf[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_toggle_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_toggle_encoder
//  Purpose  : Self-checking bench for pulse_toggle_encoder. Four instances
//             with different GAP/CW/EDGE_MODE share one stimulus stream and
//             are compared every cycle against a timestamp-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_toggle_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_v;
    logic [3:0] clr_v;
    logic [3:0] d_out  [4];
    logic [3:0] d_busy [4];
    logic [3:0] d_ovf  [4];

    always #5 clk = ~clk;

    // Instance parameters, mirrored in the model tables below
    pulse_toggle_encoder #(.N(4), .CW(3), .GAP(2), .EDGE_MODE(0)) u0 (
        .clk(clk), .reset(reset), .in(in_v), .ovf_clr(clr_v),
        .out(d_out[0]), .busy(d_busy[0]), .ovf(d_ovf[0]));
    pulse_toggle_encoder #(.N(4), .CW(3), .GAP(3), .EDGE_MODE(0)) u1 (
        .clk(clk), .reset(reset), .in(in_v), .ovf_clr(clr_v),
        .out(d_out[1]), .busy(d_busy[1]), .ovf(d_ovf[1]));
    pulse_toggle_encoder #(.N(4), .CW(2), .GAP(4), .EDGE_MODE(0)) u2 (
        .clk(clk), .reset(reset), .in(in_v), .ovf_clr(clr_v),
        .out(d_out[2]), .busy(d_busy[2]), .ovf(d_ovf[2]));
    pulse_toggle_encoder #(.N(4), .CW(2), .GAP(1), .EDGE_MODE(1)) u3 (
        .clk(clk), .reset(reset), .in(in_v), .ovf_clr(clr_v),
        .out(d_out[3]), .busy(d_busy[3]), .ovf(d_ovf[3]));

    int GAPV [4] = '{2, 3, 4, 1};
    int MAXV [4] = '{7, 7, 3, 3};
    bit EDGEV[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Model: backlog count plus timestamp of the last flip per channel
    int m_pend [4][4];
    int m_last [4][4];
    bit m_out  [4][4];
    bit m_ovf  [4][4];
    bit m_prev [4][4];
    int cyc = 0;

    int         flips [4][4];
    logic [3:0] prev_out [4] = '{default: 4'b0};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] in;
        logic [3:0] clr;
        logic [3:0] e_out;
        logic [3:0] e_busy;
        logic [3:0] e_ovf;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit ev, fire, drop;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    m_out[k][i]  = 1'b0;
                    m_pend[k][i] = 0;
                    m_ovf[k][i]  = 1'b0;
                    m_last[k][i] = -1000;
                    m_prev[k][i] = in_v[i];
                end else begin
                    ev   = EDGEV[k] ? (in_v[i] && !m_prev[k][i]) : in_v[i];
                    m_prev[k][i] = in_v[i];
                    fire = ((cyc - m_last[k][i]) >= GAPV[k]) && ((m_pend[k][i] > 0) || ev);
                    drop = 1'b0;
                    if (fire) begin
                        m_out[k][i]  = !m_out[k][i];
                        m_last[k][i] = cyc;
                        if (!ev) m_pend[k][i] = m_pend[k][i] - 1;
                    end else if (ev) begin
                        if (m_pend[k][i] < MAXV[k]) m_pend[k][i] = m_pend[k][i] + 1;
                        else drop = 1'b1;
                    end
                    if (drop) m_ovf[k][i] = 1'b1;
                    else if (clr_v[i]) m_ovf[k][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] e_out, e_busy, e_ovf;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                e_out[i]  = m_out[k][i];
                e_ovf[i]  = m_ovf[k][i];
                // Timer still running while fewer than GAP-1 edges have passed since the flip
                e_busy[i] = (m_pend[k][i] != 0) || ((cyc - m_last[k][i]) < (GAPV[k] - 1));
            end
            chk($sformatf("u%0d_out", k),  32'(d_out[k]),  32'(e_out));
            chk($sformatf("u%0d_busy", k), 32'(d_busy[k]), 32'(e_busy));
            chk($sformatf("u%0d_ovf", k),  32'(d_ovf[k]),  32'(e_ovf));
        end
    endtask

    // One clock: drive, let the edge happen, update model, sample 1 ns later
    task automatic step(input logic r, input logic [3:0] i, input logic [3:0] c);
        reset = r;
        in_v  = i;
        clr_v = c;
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (d_out[k][b] !== prev_out[k][b]) flips[k][b]++;
            end
            prev_out[k] = d_out[k];
        end
        model_check();
    endtask

    task automatic clear_flips();
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                flips[k][b] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_v  = 4'b0;
        clr_v = 4'b0;

        // Hand-derived vectors for u0 (GAP=2, CW=3, level mode)
        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        tbl[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[3] = '{1'b0, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0000};
        tbl[4] = '{1'b0, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0000};
        tbl[5] = '{1'b0, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        tbl[6] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        tbl[7] = '{1'b0, 4'b0000, 4'b0000, 4'b0011, 4'b0010, 4'b0000};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000};

        for (int v = 0; v < 9; v++) begin
            step(tbl[v].rst, tbl[v].in, tbl[v].clr);
            chk($sformatf("tbl%0d_out", v),  32'(d_out[0]),  32'(tbl[v].e_out));
            chk($sformatf("tbl%0d_busy", v), 32'(d_busy[0]), 32'(tbl[v].e_busy));
            chk($sformatf("tbl%0d_ovf", v),  32'(d_ovf[0]),  32'(tbl[v].e_ovf));
        end

        // Burst on u1 (GAP=3): four events, four flips three cycles apart
        step(1'b1, 4'b0, 4'b0);
        clear_flips();
        repeat (4) step(1'b0, 4'b0010, 4'b0);
        repeat (12) step(1'b0, 4'b0, 4'b0);
        chk("burst_flips", 32'(flips[1][1]), 32'd4);
        chk("burst_ovf", 32'(d_ovf[1][1]), 32'd0);

        // Overflow on u2 (GAP=4, CW=2): six events, the sixth is dropped
        step(1'b1, 4'b0, 4'b0);
        clear_flips();
        repeat (6) step(1'b0, 4'b0100, 4'b0);
        chk("ovf_set", 32'(d_ovf[2][2]), 32'd1);
        repeat (20) step(1'b0, 4'b0, 4'b0);
        chk("ovf_flips", 32'(flips[2][2]), 32'd5);
        chk("ovf_sticky", 32'(d_ovf[2][2]), 32'd1);
        step(1'b0, 4'b0, 4'b0100);
        chk("ovf_clr", 32'(d_ovf[2][2]), 32'd0);

        // Edge mode on u3: a long high level is one event
        step(1'b1, 4'b0, 4'b0);
        clear_flips();
        repeat (10) step(1'b0, 4'b0001, 4'b0);
        repeat (3) step(1'b0, 4'b0, 4'b0);
        chk("edge_flips", 32'(flips[3][0]), 32'd1);
        step(1'b1, 4'b0001, 4'b0);
        clear_flips();
        repeat (5) step(1'b0, 4'b0001, 4'b0);
        chk("edge_rst_flips", 32'(flips[3][0]), 32'd0);

        // Reset with backlog pending on u0 (pend reaches 3)
        step(1'b1, 4'b0, 4'b0);
        repeat (6) step(1'b0, 4'b0001, 4'b0);
        step(1'b1, 4'b0, 4'b0);
        chk("rst_out", 32'(d_out[0]), 32'd0);
        chk("rst_busy", 32'(d_busy[0]), 32'd0);
        clear_flips();
        repeat (10) step(1'b0, 4'b0, 4'b0);
        chk("rst_noflip", 32'(flips[0][0]), 32'd0);

        // u2 channel 3: full backlog plus event on a firing cycle, then drop vs clear
        step(1'b1, 4'b0, 4'b0);
        repeat (5) step(1'b0, 4'b1000, 4'b0);
        chk("full_fire_ovf", 32'(d_ovf[2][3]), 32'd0);
        chk("full_fire_busy", 32'(d_busy[2][3]), 32'd1);
        step(1'b0, 4'b1000, 4'b1000);
        chk("drop_beats_clr", 32'(d_ovf[2][3]), 32'd1);

        // Randomized traffic against the model
        step(1'b1, 4'b0, 4'b0);
        for (int t = 0; t < 600; t++) begin
            logic       r;
            logic [3:0] iv, cv;
            int         dense;
            r     = ($urandom_range(0, 79) == 0);
            dense = ((t / 50) % 2);
            for (int b = 0; b < 4; b++) begin
                iv[b] = dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
                cv[b] = ($urandom_range(0, 9) == 0);
            end
            step(r, iv, cv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
